// File: rtl/tcam_sched_pkg.sv
// Shared types and defaults for the TCAM lookup scheduler.
// FSM state encoding, key/index widths and timeout-counter sizing.
package tcam_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int KEY_W_DEF       = 128;
    localparam int IDX_W_DEF       = 6;
    localparam int TIMEOUT_CYC_DEF = 64;

    // Counter holds 0 .. cyc-1 WAIT cycles
    function automatic int to_cnt_w(input int cyc);
        return (cyc < 3) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
// Returns one-hot grant, its index and an any-valid flag.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       any_o
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] idx;

    // Scan offsets high to low so the smallest offset from ptr wins
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ptr_i + IW'(k);
            if (req_i[idx]) begin
                gnt_idx_o = idx;
                any_o     = 1'b1;
            end
        end
        if (any_o) gnt_o[gnt_idx_o] = 1'b1;
    end

endmodule

// File: rtl/tcam_lookup_sched.sv
// Round-robin scheduler sharing one TCAM lookup port, one lookup in flight.
// Optional WAIT-state timeout enabled by defining TCAM_LOOKUP_TIMEOUT_EN.
module tcam_lookup_sched
    import tcam_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int KEY_W       = KEY_W_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*KEY_W-1:0]   req_key,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tcam_req_valid,
    input  logic                       tcam_req_ready,
    output logic [KEY_W-1:0]           tcam_key,
    input  logic                       tcam_rsp_valid,
    input  logic                       tcam_rsp_hit,
    input  logic [IDX_W-1:0]           tcam_rsp_index,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic                       resp_hit,
    output logic [IDX_W-1:0]           resp_index,
    output logic                       resp_timeout
);
    localparam int IW = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      id_q, id_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic               hit_q, hit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               to_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

`ifdef TCAM_LOOKUP_TIMEOUT_EN
    localparam int CW = to_cnt_w(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          to_q, to_d;

    assign to_hit = (state_q == ST_WAIT)
                 && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // WAIT cycle counter and timeout flag; a real response beats timeout
    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (state_q == ST_ISSUE) cnt_d = '0;
        if (state_q == ST_WAIT) begin
            cnt_d = cnt_q + CW'(1);
            if (tcam_rsp_valid) to_d = 1'b0;
            else if (to_hit)    to_d = 1'b1;
        end
    end

    // Timeout state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign resp_timeout = to_q;
`else
    logic unused_to;
    assign unused_to    = ^TIMEOUT_CYC;
    assign to_hit       = 1'b0;
    assign resp_timeout = 1'b0;
`endif

    // Next-state logic, grant and result capture
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        key_d     = key_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        req_ready = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt;
                    key_d     = req_key[int'(gnt_idx)*KEY_W +: KEY_W];
                    id_d      = gnt_idx;
                    ptr_d     = gnt_idx + IW'(1);
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tcam_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tcam_rsp_valid) begin
                    hit_d   = tcam_rsp_hit;
                    idx_d   = tcam_rsp_hit ? tcam_rsp_index : '0;
                    state_d = ST_RESP;
                end else if (to_hit) begin
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            key_q   <= '0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            key_q   <= key_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
        end
    end

    assign tcam_req_valid = (state_q == ST_ISSUE);
    assign resp_valid     = (state_q == ST_RESP);
    assign tcam_key       = key_q;
    assign resp_id        = id_q;
    assign resp_hit       = hit_q;
    assign resp_index     = idx_q;

endmodule

// File: tb/tb_tcam_lookup_sched.sv
// Testbench for tcam_lookup_sched: directed cases plus randomized traffic
// against a transaction-level reference model.
module tb_tcam_lookup_sched;
    localparam int N  = 4;
    localparam int KW = 128;
    localparam int XW = 6;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*KW-1:0] req_key;
    logic [N-1:0]   req_ready;
    logic           tcam_req_valid;
    logic           tcam_req_ready;
    logic [KW-1:0]  tcam_key;
    logic           tcam_rsp_valid;
    logic           tcam_rsp_hit;
    logic [XW-1:0]  tcam_rsp_index;
    logic           resp_valid;
    logic           resp_ready;
    logic [1:0]     resp_id;
    logic           resp_hit;
    logic [XW-1:0]  resp_index;
    logic           resp_timeout;

    tcam_lookup_sched #(
        .NUM_REQ(N), .KEY_W(KW), .IDX_W(XW), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
        .tcam_req_valid(tcam_req_valid), .tcam_req_ready(tcam_req_ready),
        .tcam_key(tcam_key), .tcam_rsp_valid(tcam_rsp_valid),
        .tcam_rsp_hit(tcam_rsp_hit), .tcam_rsp_index(tcam_rsp_index),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_hit(resp_hit),
        .resp_index(resp_index), .resp_timeout(resp_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [KW-1:0] got,
                       input logic [KW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [KW-1:0] rnd_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: pending requests, pointer, transaction phase flags
    logic [N-1:0]  pend;
    logic [KW-1:0] keys [N];
    int            ptr;
    bit            busy, issuing, resp_pend;
    int            timer;
    logic [KW-1:0] e_key;
    int            e_id;
    logic          e_hit;
    logic [XW-1:0] e_idx;
    int            grants[$];
    int            n_done;

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++)
            if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_key = '0;
        tcam_req_ready = 1'b0;
        tcam_rsp_valid = 1'b0;
        tcam_rsp_hit = 1'b0;
        tcam_rsp_index = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        pend = '0;
        for (int i = 0; i < N; i++) keys[i] = '0;
        ptr = 0;
        busy = 0;
        issuing = 0;
        resp_pend = 0;
        timer = 0;
        grants.delete();
        n_done = 0;
    endtask

    // Random traffic; model derives expectations from the handshake rules
    task automatic run(input int ncyc, input int p_new,
                       input int p_trdy, input int p_rrdy);
        for (int c = 0; c < ncyc; c++) begin
            int g;
            bit fire;
            logic [N-1:0] exp_rr;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(99) < p_new) begin
                    pend[i] = 1'b1;
                    keys[i] = rnd_key();
                end
                req_key[i*KW +: KW] = keys[i];
            end
            req_valid = pend;
            tcam_rsp_valid = 1'b0;
            tcam_rsp_hit = 1'($urandom());
            tcam_rsp_index = XW'($urandom());
            fire = 0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    tcam_rsp_valid = 1'b1;
                    fire = 1;
                end
            end else if ($urandom_range(9) == 0) begin
                tcam_rsp_valid = 1'b1;
            end
            tcam_req_ready = ($urandom_range(99) < p_trdy);
            resp_ready = ($urandom_range(99) < p_rrdy);
            #1;
            g = busy ? -1 : pick(pend, ptr);
            exp_rr = '0;
            if (g >= 0) exp_rr[g] = 1'b1;
            chk("req_ready", req_ready, exp_rr);
            chk("tcam_req_valid", tcam_req_valid, issuing);
            if (issuing) chk("tcam_key", tcam_key, e_key);
            chk("resp_valid", resp_valid, resp_pend);
            if (resp_pend) begin
                chk("resp_id", resp_id, e_id);
                chk("resp_hit", resp_hit, e_hit);
                chk("resp_index", resp_index, e_idx);
                chk("resp_timeout", resp_timeout, 0);
            end
            if (resp_pend && resp_ready) begin
                resp_pend = 0;
                busy = 0;
                n_done++;
            end
            if (fire) begin
                resp_pend = 1;
                e_hit = tcam_rsp_hit;
                e_idx = tcam_rsp_hit ? tcam_rsp_index : '0;
            end
            if (issuing && tcam_req_ready) begin
                issuing = 0;
                timer = $urandom_range(1, 4);
            end
            if (g >= 0) begin
                busy = 1;
                issuing = 1;
                ptr = (g + 1) % N;
                pend[g] = 1'b0;
                e_key = keys[g];
                e_id = g;
                grants.push_back(g);
            end
            tick();
        end
    endtask

    // Grant requester 0 and have the TCAM accept at once; ends in WAIT
    task automatic grant0_and_accept();
        req_valid = 4'b0001;
        req_key[KW-1:0] = rnd_key();
        tcam_req_ready = 1'b1;
        resp_ready = 1'b0;
        tick();
        req_valid = '0;
        tick();
    endtask

    localparam logic [KW-1:0] K2 =
        128'hC0A80001_11223344_55667788_99AABBCC;

    initial begin
        bit seen;

        do_reset();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tcam_req_valid", tcam_req_valid, 0);
        chk("rst_tcam_key", tcam_key, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_index", resp_index, 0);
        chk("rst_resp_timeout", resp_timeout, 0);

        // Single request from requester 2, 3-cycle TCAM latency
        tick();
        req_valid = 4'b0100;
        req_key[2*KW +: KW] = K2;
        tcam_req_ready = 1'b1;
        resp_ready = 1'b1;
        #1;
        chk("single_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("single_issue", tcam_req_valid, 1);
        chk("single_key", tcam_key, K2);
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            seen |= resp_valid;
        end
        tick();
        tcam_rsp_valid = 1'b1;
        tcam_rsp_hit = 1'b1;
        tcam_rsp_index = 6'd17;
        #1;
        seen |= resp_valid;
        chk("single_early", seen, 0);
        tick();
        tcam_rsp_valid = 1'b0;
        #1;
        chk("single_rvalid", resp_valid, 1);
        chk("single_id", resp_id, 2);
        chk("single_hit", resp_hit, 1);
        chk("single_idx", resp_index, 17);
        tick();
        #1;
        chk("single_done", resp_valid, 0);

        // Miss forces index to zero
        do_reset();
        grant0_and_accept();
        tcam_rsp_valid = 1'b1;
        tcam_rsp_hit = 1'b0;
        tcam_rsp_index = 6'd9;
        tick();
        tcam_rsp_valid = 1'b0;
        #1;
        chk("miss_rvalid", resp_valid, 1);
        chk("miss_hit", resp_hit, 0);
        chk("miss_idx", resp_index, 0);

        // Reset while waiting; late response ignored, pointer back to 0
        do_reset();
        req_valid = 4'b0010;
        tcam_req_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tcam_rsp_valid = 1'b1;
        tcam_rsp_hit = 1'b1;
        tcam_rsp_index = 6'd33;
        #1;
        chk("wrst_tvalid", tcam_req_valid, 0);
        chk("wrst_key", tcam_key, 0);
        chk("wrst_rvalid", resp_valid, 0);
        chk("wrst_id", resp_id, 0);
        chk("wrst_hit", resp_hit, 0);
        chk("wrst_idx", resp_index, 0);
        tick();
        tcam_rsp_valid = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("wrst_late", resp_valid, 0);
        chk("wrst_grant0", req_ready, 4'b0001);

`ifdef TCAM_LOOKUP_TIMEOUT_EN
        // No response: timeout after 64 WAIT cycles
        do_reset();
        grant0_and_accept();
        seen = 0;
        for (int k = 0; k < 64; k++) begin
            #1;
            seen |= resp_valid;
            tick();
        end
        #1;
        chk("to_early", seen, 0);
        chk("to_rvalid", resp_valid, 1);
        chk("to_flag", resp_timeout, 1);
        chk("to_hit", resp_hit, 0);
        chk("to_idx", resp_index, 0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        // Response on the 64th WAIT cycle wins over timeout
        grant0_and_accept();
        for (int k = 0; k < 63; k++) tick();
        tcam_rsp_valid = 1'b1;
        tcam_rsp_hit = 1'b1;
        tcam_rsp_index = 6'd5;
        tick();
        tcam_rsp_valid = 1'b0;
        #1;
        chk("to64_rvalid", resp_valid, 1);
        chk("to64_flag", resp_timeout, 0);
        chk("to64_hit", resp_hit, 1);
        chk("to64_idx", resp_index, 5);
`else
        // Without timeout the block waits indefinitely
        do_reset();
        grant0_and_accept();
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            seen |= resp_valid | resp_timeout;
            tick();
        end
        chk("noto_wait", seen, 0);
        tcam_rsp_valid = 1'b1;
        tcam_rsp_hit = 1'b1;
        tcam_rsp_index = 6'd40;
        tick();
        tcam_rsp_valid = 1'b0;
        #1;
        chk("noto_rvalid", resp_valid, 1);
        chk("noto_idx", resp_index, 40);
        chk("noto_flag", resp_timeout, 0);
`endif

        // Fairness: all requesters always valid from pointer 0
        do_reset();
        run(80, 100, 100, 100);
        chk("rr_count", grants.size() >= 8, 1);
        if (grants.size() >= 8)
            for (int k = 0; k < 8; k++)
                chk("rr_order", grants[k], k % N);

        // Random traffic with light and heavy backpressure
        do_reset();
        run(3000, 30, 60, 60);
        chk("rand_progress", n_done > 100, 1);
        do_reset();
        run(1500, 60, 20, 25);
        chk("bp_progress", n_done > 20, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tcam_lookup_sched.md
# tcam_lookup_sched

Round-robin scheduler that shares the single TCAM lookup port between up to NUM_REQ requesters, such as per-port parser and key-builder pipelines. It accepts one 128-bit key per grant and issues it to the TCAM with a valid/ready handshake. It waits for the TCAM result and returns hit/index tagged with the requester ID. Only one lookup is outstanding at a time, so responses are never reordered.

## Interface
Clock is `clk`. Reset is `rst`, synchronous and active-high: sampled only on the rising edge of `clk`, and all state is cleared while it is 1.

Parameters:
- NUM_REQ, 4: number of requesters; must be a power of 2, ≥2.
- KEY_W, 128: key width, matching the key-builder output.
- IDX_W, 6: TCAM entry index width.
- TIMEOUT_CYC, 64: WAIT-state cycle budget (used only with the timeout feature).

Ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req_valid  in  NUM_REQ  per-requester key valid
- req_key  in  NUM_REQ*KEY_W  requester i key at [i*KEY_W +: KEY_W]
- req_ready  out  NUM_REQ  one-hot accept pulse
- tcam_req_valid  out  1  lookup issue
- tcam_req_ready  in  1  TCAM accepts the key
- tcam_key  out  KEY_W  latched granted key
- tcam_rsp_valid  in  1  result strobe
- tcam_rsp_hit  in  1  match flag
- tcam_rsp_index  in  IDX_W  matching entry
- resp_valid  out  1  result to requester
- resp_ready  in  1  consumer accepts the result
- resp_id  out  $clog2(NUM_REQ)  granted requester
- resp_hit  out  1  hit (0 on timeout)
- resp_index  out  IDX_W  index (0 on miss or timeout)
- resp_timeout  out  1  timeout flag (tied 0 when the feature is compiled out)

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is 1, grant the first valid requester at or after rr_ptr, searching cyclically.
  - In the same cycle: req_ready[g]=1, latch req_key slice g into tcam_key, store g as resp_id, go to ISSUE.
  - rr_ptr ← (g+1) mod NUM_REQ.
- **ISSUE**
  - tcam_req_valid=1; tcam_key is held stable.
  - On tcam_req_ready=1, go to WAIT and clear the wait counter.
- **WAIT**
  - On tcam_rsp_valid=1, capture hit and index and go to RESP.
  - Index is forced to 0 when hit=0.
- **RESP**
  - resp_valid=1; resp_* fields are held stable until resp_ready=1, then go to IDLE.
- Requesters must hold req_valid and req_key until they see req_ready. req_ready is never asserted outside IDLE.
- tcam_rsp_valid arriving outside WAIT is ignored. A protocol-error counter is optional and not required.
- rr_ptr changes only on a grant. A requester left unserved waits at most NUM_REQ-1 other grants.
- Reset in any state:
  - State returns to IDLE next cycle; rr_ptr=0; the in-flight lookup is discarded.
  - A late tcam_rsp_valid arriving afterwards is ignored.
- Reset values: req_ready=0, tcam_req_valid=0, tcam_key=0, resp_valid=0, resp_id=0, resp_hit=0, resp_index=0, resp_timeout=0.

## Timing
- Grant cycle T: req_ready is combinational from state and req_valid.
- T+1: tcam_req_valid=1, registered.
- With zero TCAM stall and a response latency of L cycles after acceptance, resp_valid is registered and rises L+1 cycles after the tcam_req_ready cycle.
- RESP→IDLE on the resp_ready cycle. The next grant can occur the cycle after.
- Minimum spacing between grants: 4 cycles (IDLE, ISSUE, WAIT with a same-cycle response, RESP).
- Simultaneous requests from all requesters with rr_ptr=0 are granted in order 0,1,2,3.

## Configuration
- `TCAM_LOOKUP_TIMEOUT_EN` defined:
  - A WAIT counter runs. If it reaches TIMEOUT_CYC without tcam_rsp_valid, go to RESP with resp_hit=0, resp_index=0, resp_timeout=1.
  - A response on the same cycle as the timeout wins, so resp_timeout=0.
- Not defined:
  - The block waits in WAIT indefinitely.
  - resp_timeout is constant 0 and no counter is instantiated.

## Structure
- Package `tcam_sched_pkg`: FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3), KEY_W and IDX_W defaults, timeout-counter width.
- Sub-module `rr_arbiter` (NUM_REQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant index, any-valid.
  - Purely combinational.
- The FSM and datapath registers are in the top module.

## Test plan
- **Single request:** req_valid=4'b0100, key=128'hC0A80001_…; TCAM ready at once and responds after 3 cycles with hit=1, index=6'd17. Expect tcam_key equals the key, resp_id=2, hit=1, index=17, resp_valid 4 cycles after tcam_req_valid.
- **Round-robin fairness:** all 4 requesters held valid for 8 grants. Expect grant order 0,1,2,3,0,1,2,3.
- **Backpressure:** hold tcam_req_ready=0 for 5 cycles, then hold resp_ready=0 for 3 cycles. Expect tcam_key, resp_* and resp_valid stable throughout; no new req_ready.
- **Miss:** TCAM responds hit=0, index=6'd9. Expect resp_hit=0, resp_index=0.
- **Reset in WAIT:** assert rst for 1 cycle, then inject tcam_rsp_valid. Expect all outputs 0, no resp_valid, next grant to requester 0.
- **Timeout (macro defined, TIMEOUT_CYC=64):** no response. Expect resp_valid with resp_timeout=1 and hit=0 after 64 WAIT cycles. A response on the 64th cycle gives resp_timeout=0.
